// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op/state types, error codes, bus direction and size helpers for lsu_ctrl
package lsu_pkg;
  typedef enum logic [3:0] {
    LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_LWU, LSU_LD,
    LSU_SB, LSU_SH, LSU_SW, LSU_SD
  } lsu_op_t;
  typedef enum logic [1:0] {LSU_IDLE, LSU_BUS, LSU_RESP} lsu_state_t;
  localparam logic [1:0] LSU_ERR_OK       = 2'd0;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'd1;
  localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'd3;
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam logic [7:0] SZ_MASK_B = 8'h01;
  localparam logic [7:0] SZ_MASK_H = 8'h03;
  localparam logic [7:0] SZ_MASK_W = 8'h0F;
  localparam logic [7:0] SZ_MASK_D = 8'hFF;
  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(lsu_op_t op);
    case (op)
      LSU_LH, LSU_LHU, LSU_SH: op_size = 2'd1;
      LSU_LW, LSU_LWU, LSU_SW: op_size = 2'd2;
      LSU_LD, LSU_SD:          op_size = 2'd3;
      default:                 op_size = 2'd0;
    endcase
  endfunction
  function automatic logic [7:0] size_mask(logic [1:0] sz);
    return sz == 2'd0 ? SZ_MASK_B : sz == 2'd1 ? SZ_MASK_H : sz == 2'd2 ? SZ_MASK_W : SZ_MASK_D;
  endfunction
  function automatic logic op_store(lsu_op_t op);
    return op inside {LSU_SB, LSU_SH, LSU_SW, LSU_SD};
  endfunction
  function automatic logic op_signed(lsu_op_t op);
    return op inside {LSU_LB, LSU_LH, LSU_LW};
  endfunction
endpackage

// File: rtl/lsu_ctrl_lane_align.sv
// lsu_lane_align: byte-enable generation, store replication, load extraction and access checks
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF    = $clog2(NB)
) (
  input  lsu_op_t           op,
  input  logic [OFF-1:0]    off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_st,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              misaligned,
  output logic              illegal
);
  logic [1:0]        sz;
  logic [6:0]        bits;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] low_mask;
  logic              sgn;
  // a full-width access shifts the 1 out, so low_mask wraps to all ones
  always_comb begin
    sz         = op_size(op);
    bits       = 7'(8 << sz);
    illegal    = op > LSU_SD || (DATA_W == 32 && op inside {LSU_LWU, LSU_LD, LSU_SD});
    misaligned = |(off & OFF'((1 << sz) - 1));
    be         = NB'(size_mask(sz)) << off;
    wdata_st   = '0;
    for (int i = 0; i < NB; i++) wdata_st[8*i +: 8] = 8'(wdata >> (8 * (i & ((1 << sz) - 1))));
    lane       = rdata >> (8 * off);
    low_mask   = (DATA_W'(1) << bits) - DATA_W'(1);
    sgn        = op_signed(op) && |(lane & (DATA_W'(1) << (bits - 7'd1)));
    rdata_ext  = (lane & low_mask) | (sgn ? ~low_mask : '0);
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequential load/store controller driving a word-addressed bus with wait states
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 32,
  parameter  int TIMEOUT = 16,
  localparam int NB      = DATA_W / 8,
  localparam int OFF     = $clog2(NB),
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  mem_as_,
  output logic                  mem_rw,
  output logic [ADDR_W-OFF-1:0] mem_addr,
  output logic [NB-1:0]         mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_rdy,
  input  logic [DATA_W-1:0]     mem_rdata
);
  lsu_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  lsu_op_t               op_q, op_d, op_sel;
  logic [OFF-1:0]        off_q, off_d, off_sel;
  logic [ADDR_W-OFF-1:0] addr_q, addr_d;
  logic [NB-1:0]         be_q, be_d, be;
  logic [DATA_W-1:0]     wdata_q, wdata_d, wdata_st, rdata_ext;
  logic                  rw_q, rw_d, misaligned, illegal;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_err_q, rsp_err_d;
  // the aligner checks the incoming request in IDLE and extracts with the latched access in BUS
  assign op_sel  = state_q == LSU_IDLE ? lsu_op_t'(req_op) : op_q;
  assign off_sel = state_q == LSU_IDLE ? req_addr[OFF-1:0] : off_q;
  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .op        (op_sel),
    .off       (off_sel),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_st  (wdata_st),
    .rdata_ext (rdata_ext),
    .misaligned(misaligned),
    .illegal   (illegal)
  );
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    rsp_rdata_d = '0;
    rsp_err_d   = LSU_ERR_OK;
    if (state_q == LSU_IDLE && req_valid && op_sel != LSU_NONE) begin
      if (illegal || misaligned) begin
        state_d   = LSU_RESP;
        rsp_err_d = illegal ? LSU_ERR_ILLEGAL : LSU_ERR_MISALIGN;
      end else begin
        state_d = LSU_BUS;
        cnt_d   = '0;
        op_d    = op_sel;
        off_d   = off_sel;
        addr_d  = req_addr[ADDR_W-1:OFF];
        be_d    = be;
        wdata_d = wdata_st;
        rw_d    = op_store(op_sel) ? WRITE : READ;
      end
    end else if (state_q == LSU_BUS) begin
      if (mem_rdy) begin
        state_d     = LSU_RESP;
        rsp_rdata_d = rw_q == READ ? rdata_ext : '0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d   = LSU_RESP;
        rsp_err_d = LSU_ERR_TIMEOUT;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (state_q == LSU_RESP) begin
      state_d = LSU_IDLE;
    end
    rsp_valid_d = state_d == LSU_RESP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      cnt_q       <= '0;
      op_q        <= LSU_NONE;
      off_q       <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rw_q        <= READ;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= LSU_ERR_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
  assign req_ready = state_q == LSU_IDLE;
  assign mem_as_   = state_q != LSU_BUS;
  assign mem_rw    = rw_q;
  assign mem_addr  = addr_q;
  assign mem_be    = state_q == LSU_BUS ? be_q : '0;
  assign mem_wdata = state_q == LSU_BUS ? wdata_q : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed plus random transactions on 32- and 64-bit controllers against an arithmetic model
module tb_lsu_ctrl;
  import lsu_pkg::*;
  localparam int T32 = 4;
  localparam int T64 = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        rv32 = 1'b0, rv64 = 1'b0, mem_rdy = 1'b0, w64 = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0, rdata = '0;
  logic        rdy32, rsv32, as32, rw32, rdy64, rsv64, as64, rw64;
  logic [31:0] rd32, wd32;
  logic [63:0] rd64, wd64;
  logic [1:0]  err32, err64;
  logic [29:0] ma32;
  logic [28:0] ma64;
  logic [3:0]  be32;
  logic [7:0]  be64;
  int total = 0, bad = 0;
  lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(T32)) u32 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv32), .req_ready(rdy32), .req_op(op),
    .req_addr(addr), .req_wdata(wdata[31:0]), .rsp_valid(rsv32), .rsp_rdata(rd32),
    .rsp_err(err32), .mem_as_(as32), .mem_rw(rw32), .mem_addr(ma32), .mem_be(be32),
    .mem_wdata(wd32), .mem_rdy(mem_rdy), .mem_rdata(rdata[31:0])
  );
  lsu_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(T64)) u64 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv64), .req_ready(rdy64), .req_op(op),
    .req_addr(addr), .req_wdata(wdata), .rsp_valid(rsv64), .rsp_rdata(rd64),
    .rsp_err(err64), .mem_as_(as64), .mem_rw(rw64), .mem_addr(ma64), .mem_be(be64),
    .mem_wdata(wd64), .mem_rdy(mem_rdy), .mem_rdata(rdata)
  );
  logic        o_ready, o_as, o_rw, o_rv;
  logic [1:0]  o_err;
  logic [63:0] o_rd, o_wd;
  logic [7:0]  o_be;
  logic [31:0] o_addr;
  assign o_ready = w64 ? rdy64 : rdy32;
  assign o_as    = w64 ? as64 : as32;
  assign o_rw    = w64 ? rw64 : rw32;
  assign o_rv    = w64 ? rsv64 : rsv32;
  assign o_err   = w64 ? err64 : err32;
  assign o_rd    = w64 ? rd64 : {32'b0, rd32};
  assign o_wd    = w64 ? wd64 : {32'b0, wd32};
  assign o_be    = w64 ? be64 : {4'b0, be32};
  assign o_addr  = w64 ? {ma64, 3'b0} : {ma32, 2'b0};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int sz_of(logic [3:0] o);
    case (o)
      4'd1, 4'd4, 4'd8:  return 1;
      4'd2, 4'd5, 4'd9:  return 2;
      4'd3, 4'd6, 4'd10: return 4;
      4'd7, 4'd11:       return 8;
      default:           return 0;
    endcase
  endfunction
  function automatic bit legal(bit wide, logic [3:0] o);
    return o >= 4'd1 && o <= 4'd11 && (wide || !(o inside {4'd6, 4'd7, 4'd11}));
  endfunction
  // arithmetic view: take the addressed bytes, reinterpret as two's complement if signed
  function automatic logic [63:0] load_model(bit wide, logic [3:0] o, int off, logic [63:0] rd);
    int bits = 8 * sz_of(o);
    logic [63:0] u = (wide ? rd : {32'b0, rd[31:0]}) >> (8 * off);
    if (bits < 64) begin
      u = u % (64'd1 << bits);
      if (o inside {4'd1, 4'd2, 4'd3} && u >= (64'd1 << (bits - 1))) u = u - (64'd1 << bits);
    end
    return wide ? u : (u & 64'hFFFF_FFFF);
  endfunction
  task automatic txn(input bit wide, input logic [3:0] o, input logic [31:0] a,
                     input logic [63:0] wd, input logic [63:0] rd, input int waits);
    int nb, sz, tmo, off;
    logic [1:0]  eerr;
    logic [63:0] ebe, ewd, erd;
    bit st;
    nb = wide ? 8 : 4;
    tmo = wide ? T64 : T32;
    sz = sz_of(o);
    off = int'(a) & (nb - 1);
    @(negedge clk);
    w64 = wide;
    #1 chk("ready_idle", o_ready, 1);
    op = o; addr = a; wdata = wd; mem_rdy = 1'($urandom_range(0, 1));
    rdata = {$urandom, $urandom};
    if (wide) rv64 = 1'b1; else rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0; rv64 = 1'b0; mem_rdy = 1'b0;
    if (o == 4'd0) begin
      chk("none_rsp", o_rv, 0);
      chk("none_as", o_as, 1);
      chk("none_ready", o_ready, 1);
      return;
    end
    eerr = !legal(wide, o) ? 2'd2 : (int'(a) % sz != 0) ? 2'd1 : 2'd0;
    if (eerr != 2'd0) begin
      chk("err_rsp", o_rv, 1);
      chk("err_code", o_err, eerr);
      chk("err_rdata", o_rd, 0);
      chk("err_as", o_as, 1);
      @(negedge clk);
      chk("err_rsp_drop", o_rv, 0);
      chk("err_ready", o_ready, 1);
      return;
    end
    ebe = ((64'd1 << sz) - 64'd1) << off;
    ewd = '0;
    for (int i = 0; i < nb; i++) ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
    st = o >= 4'd8;
    erd = st ? 64'd0 : load_model(wide, o, off, rd);
    for (int k = 0; k < tmo; k++) begin
      chk("bus_as", o_as, 0);
      chk("bus_be", o_be, ebe);
      chk("bus_wdata", o_wd, ewd);
      chk("bus_addr", o_addr, a & ~32'(nb - 1));
      chk("bus_rw", o_rw, st ? WRITE : READ);
      chk("bus_rsp", o_rv, 0);
      if (k == waits) begin
        mem_rdy = 1'b1; rdata = rd;
        @(negedge clk);
        break;
      end
      mem_rdy = 1'b0; rdata = {$urandom, $urandom};
      @(negedge clk);
      if (k == tmo - 1) begin
        eerr = 2'd3; erd = '0;
      end
    end
    mem_rdy = 1'($urandom_range(0, 1));
    chk("rsp_valid", o_rv, 1);
    chk("rsp_err", o_err, eerr);
    chk("rsp_rdata", o_rd, erd);
    chk("rsp_as", o_as, 1);
    chk("rsp_be", o_be, 0);
    chk("rsp_wdata", o_wd, 0);
    @(negedge clk);
    mem_rdy = 1'b0;
    chk("rsp_drop", o_rv, 0);
    chk("rsp_ready", o_ready, 1);
    chk("rsp_as_after", o_as, 1);
  endtask
  initial begin
    logic [3:0]  o;
    logic [31:0] a;
    bit wide;
    int sz;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      w64 = 1'(w);
      #1;
      chk("rst_ready", o_ready, 1);
      chk("rst_as", o_as, 1);
      chk("rst_rw", o_rw, READ);
      chk("rst_rsp", o_rv, 0);
      chk("rst_rdata", o_rd, 0);
      chk("rst_err", o_err, 0);
      chk("rst_addr", o_addr, 0);
      chk("rst_be", o_be, 0);
      chk("rst_wdata", o_wd, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, LSU_LB, 32'h1003, 64'h0, 64'h80FF_FF12, 0);
    txn(0, LSU_SH, 32'h2002, 64'h0000_ABCD, 64'h0, 3);
    txn(0, LSU_LW, 32'h3001, 64'h0, 64'h0, 0);
    txn(0, LSU_SD, 32'h0008, 64'h1122_3344_5566_7788, 64'h0, 0);
    txn(1, LSU_SD, 32'h0008, 64'h1122_3344_5566_7788, 64'h0, 1);
    txn(0, LSU_LW, 32'h0040, 64'h0, 64'hDEAD_BEEF, 100);
    txn(1, LSU_LD, 32'h0010, 64'h0, 64'hFEDC_BA98_7654_3210, 100);
    txn(1, LSU_LW, 32'h0104, 64'h0, 64'h8000_0001_0000_0000, 0);
    txn(1, LSU_LWU, 32'h0104, 64'h0, 64'h8000_0001_0000_0000, 2);
    txn(0, LSU_NONE, 32'h0, 64'h0, 64'h0, 0);
    txn(0, 4'd13, 32'h0, 64'h0, 64'h0, 0);
    // reset during the second bus cycle abandons the access
    @(negedge clk);
    w64 = 1'b0; op = LSU_LW; addr = 32'h400; mem_rdy = 1'b0; rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0;
    chk("rstmid_bus1", o_as, 0);
    @(negedge clk);
    chk("rstmid_bus2", o_as, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_as", o_as, 1);
    chk("rstmid_be", o_be, 0);
    chk("rstmid_rsp", o_rv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_norsp", o_rv, 0);
      chk("rstmid_ready", o_ready, 1);
      chk("rstmid_idle_as", o_as, 1);
    end
    mem_rdy = 1'b0;
    for (int n = 0; n < 250; n++) begin
      wide = 1'($urandom_range(0, 1));
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      sz = sz_of(o);
      if (sz != 0 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      txn(wide, o, a, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 1)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Parametrised, sequential load/store controller that replaces the single-cycle combinational memory control path between the execute stage and the data memory bus. It accepts one load/store request at a time through a valid/ready handshake and drives a word-addressed bus with byte enables, tolerating wait states. It performs lane steering and sign/zero extension for sub-word accesses, and returns data plus an error code (misaligned, illegal op, bus timeout) through a one-cycle response strobe.

## Interface
Parameters:
- `DATA_W`, 32: bus and GPR data width; legal values are 32 or 64.
- `ADDR_W`, 32: byte address width.
- `TIMEOUT`, 16: maximum number of bus cycles without `mem_rdy` before an access is aborted; must be at least 1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request (IDLE only).
- `req_op` in 4: operation code, `lsu_op_t`.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in `DATA_W`: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion strobe.
- `rsp_rdata` out `DATA_W`: extended load data; 0 for stores and errors.
- `rsp_err` out 2: 0 = OK, 1 = misaligned, 2 = illegal op, 3 = bus timeout.
- `mem_as_` out 1: active-low address strobe.
- `mem_rw` out 1: `READ`/`WRITE`, using the codebase macros.
- `mem_addr` out `ADDR_W-OFF`: word address, where `OFF = log2(DATA_W/8)`.
- `mem_be` out `DATA_W/8`: byte enables, active high.
- `mem_wdata` out `DATA_W`: lane-steered store data.
- `mem_rdy` in 1: bus completes the access this cycle.
- `mem_rdata` in `DATA_W`: read data, valid when `mem_rdy` is high.

## Operation
Ops:
- NONE, LB, LH, LW, LBU, LHU, LWU, LD, SB, SH, SW, SD.
- LWU, LD and SD are illegal when `DATA_W` = 32.
- Any unlisted code is illegal.

State machine, `lsu_state_t`:
- IDLE:
  - `req_ready` = 1.
  - `req_valid` with NONE: no action.
  - `req_valid` with an illegal op or a misaligned address: latch the error and go to RESP; the bus is never touched.
  - Otherwise, latch op, address, `be` and steered data, and go to BUS.
- BUS:
  - `mem_as_` = 0; address, `be`, `rw` and `wdata` are held stable.
  - `mem_rdy` = 1: capture the extracted load data and go to RESP.
  - Otherwise the wait counter increments.
  - Counter reaching `TIMEOUT-1` without `mem_rdy`: set err = 3 and go to RESP.
- RESP: `rsp_valid` = 1 for exactly one cycle, then go to IDLE. There is no response backpressure.

Alignment rules:
- Half-word: `addr[0]` must be 0.
- Word: `addr[1:0]` must be 0.
- Double-word: `addr[2:0]` must be 0.
- Byte accesses are always aligned.

Lane steering, with `off = addr[OFF-1:0]`:
- `mem_be` = size mask (1, 3, 0xF, 0xFF) << `off`.
- `mem_wdata` = store data replicated across all lanes of its size.

Load extraction:
- `lane = mem_rdata >> (8*off)`.
- Truncate to the access size, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to `DATA_W`.

Other rules:
- `mem_as_` = 1, `mem_be` = 0 and `mem_wdata` = 0 whenever the state is not BUS.
- `mem_rdy` outside BUS is ignored.

## Timing
Reset values:
- State = IDLE, counter = 0.
- `req_ready` = 1, `mem_as_` = 1, `mem_rw` = `READ`.
- `rsp_valid` = 0; `rsp_rdata`, `rsp_err`, `mem_addr`, `mem_be`, `mem_wdata` = 0.

Latency:
- Request accepted at edge N.
- BUS during cycle N+1.
- With `mem_rdy` high in that first BUS cycle, `rsp_valid` is high in cycle N+2.
- Each wait state adds one cycle.
- An error detected in IDLE responds in cycle N+1 with no BUS cycle.

Throughput: at most one request per 3 cycles.

Timeout: `mem_rdy` low for `TIMEOUT` consecutive BUS cycles gives `rsp_err` = 3 in the following cycle. A late `mem_rdy` after that point is ignored.

Reset mid-access:
- The state returns to IDLE asynchronously and `mem_as_` deasserts immediately.
- No response is issued for the abandoned request.

Outputs:
- `req_ready` and `mem_*` are registered or decoded from registered state only; there is no combinational path from `req_*` to `mem_*`.
- `rsp_*` are registered.

## Structure
Shared package `lsu_pkg`:
- `lsu_op_t` encodings.
- `lsu_state_t`.
- Error codes `LSU_ERR_*`.
- Size masks.

Sub-module `lsu_lane_align`, purely combinational:
- Inputs: op, off, wdata, rdata.
- Outputs: be, steered wdata, extracted rdata, misaligned, illegal.
- The FSM and counter remain in `lsu_ctrl`.

## Test plan
- LB at addr 0x1003 with `mem_rdata` 0x80FF_FF12 (`DATA_W` 32), zero wait -> `mem_be` = 0x8, `rsp_rdata` = 0xFFFF_FF80, `rsp_valid` at N+2.
- SH at 0x2002 with wdata 0x0000_ABCD, `mem_rdy` delayed 3 cycles -> `mem_be` = 0xC, `mem_wdata` = 0xABCD_ABCD held for 4 BUS cycles, err = 0.
- LW at 0x3001 -> err = 1 at N+1, `mem_as_` never low.
- SD with `DATA_W` 32 -> err = 2.
- SD with `DATA_W` 64 at 0x08 -> `mem_be` = 0xFF, succeeds.
- `TIMEOUT` = 4 with `mem_rdy` held low -> exactly 4 BUS cycles, then err = 3, `rsp_rdata` = 0.
- `rst_n` pulsed low in the 2nd BUS cycle -> `mem_as_` = 1 immediately, no `rsp_valid`, `req_ready` = 1 after release.
